jt12_kon_wr: RTL
================

Name: jt12_kon_wr

Overview:
- CPU-side producer of the key-on update stream consumed by the operator key-on shift register.
- Decodes writes to register 0x28 in bank 0 from the YM2612-style CPU port and queues them.
- Presents each queued write on keyon_op/keyon_ch with up_keyon held for one full slot revolution, so every channel/operator slot sees the update exactly once.
- Sits between the CPU bus interface and the key-on tracker inside jt12.

Parameters:
- FIFO_DEPTH, 4, number of queued key-on writes; power of two, 2..16.
- HOLD, 24, number of clk_en ticks up_keyon stays asserted per entry; equals the slot count of one full revolution.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- clk_en  in  1  slot-advance enable shared with the key-on tracker
- cpu_cs_n  in  1  chip select, active-low
- cpu_wr_n  in  1  write strobe, active-low, synchronous to clk
- cpu_addr  in  2  bit0: 0 = address write, 1 = data write; bit1: bank select
- cpu_din  in  8  CPU data
- keyon_op  out  4  operator mask {S4,S3,S2,S1} = cpu_din[7:4]
- keyon_ch  out  3  channel code = cpu_din[2:0]; same encoding as cur_ch
- up_keyon  out  1  update valid
- busy  out  1  high while the FIFO is non-empty or up_keyon is high
- ovf  out  1  one-clk pulse when a valid key-on write is dropped because the FIFO is full

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs become 0; address latch = 0x00, bank = 0.
  - FIFO emptied, hold counter = 0, FSM = IDLE.
  - Applies mid-hold: up_keyon falls at that edge and the entry is lost.
- Write strobe: accepted once per strobe, on the clk where cs_n and wr_n are both low and the previous sample of (cs_n|wr_n) was high. A strobe held low does not repeat. CPU writes are evaluated every clk, independent of clk_en.
- Address write (cpu_addr[0]=0): latch = cpu_din, bank latch = cpu_addr[1].
- Data write (cpu_addr[0]=1): enqueue {cpu_din[7:4], cpu_din[2:0]} only when all of the following hold:
  - latch == 0x28
  - bank latch == 0
  - cpu_addr[1] == 0
  - cpu_din[1:0] != 2'b11
  Codes 3 and 7 are silently ignored: no enqueue, no ovf. All other data writes are ignored.
- Full FIFO: a valid write is dropped and ovf pulses for 1 clk. If a pop occurs in the same clk, the write is accepted and there is no ovf.
- FSM, IDLE:
  - On clk_en with FIFO non-empty: pop the head into keyon_op/keyon_ch, set up_keyon=1, counter=HOLD-1, go to HOLD.
  - Minimum latency: an entry enqueued at edge t appears at the first clk_en edge after t. An enqueue and a pop never occur on the same edge for an empty FIFO.
- FSM, HOLD:
  - On each clk_en: if counter != 0, decrement.
  - If counter == 0 and the FIFO is non-empty: pop the next entry, reload counter=HOLD-1, keep up_keyon=1 (gapless).
  - If counter == 0 and the FIFO is empty: up_keyon=0, go to IDLE.
- keyon_op/keyon_ch are stable for the entire up_keyon high period. They hold their last value after up_keyon falls.
- busy = (FIFO count != 0) | up_keyon, registered.
- Counter width: clog2(HOLD). FIFO pointers wrap modulo FIFO_DEPTH, with count stored in clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- JT12_KON_WR_MERGE_EN
- Defined: a valid write whose keyon_ch matches an entry already queued (not the one currently held) overwrites that entry's keyon_op in place. There is no new enqueue and no ovf, even when the FIFO is full. The last write per channel wins.
- Undefined: every valid write occupies its own FIFO slot; overflow is handled as above.

Decomposition:
- Shared package jt12_kon_pkg:
  - constant KON_REG_ADDR = 8'h28
  - constant SLOTS = 24
  - typedef kon_entry_t {op[3:0], ch[2:0]}
- One natural sub-module: jt12_kon_fifo, a synchronous FIFO of kon_entry_t.
  - Signals: push, pop, full, empty, count.
  - Exposes a per-entry channel-match write port, used only with JT12_KON_WR_MERGE_EN.

Test Plan:
- Address 0x28 (addr=0), data 0xF1 (addr=1), clk_en every clk -> next clk: up_keyon=1, keyon_op=0xF, keyon_ch=1 for exactly 24 clk_en ticks; busy falls with up_keyon.
- Data 0x33 and 0x17 after address 0x28 -> no enqueue, up_keyon stays 0, ovf stays 0; bank-1 address 0x28 (addr=2) then data 0xF0 (addr=3) -> ignored.
- Five back-to-back valid writes (ch 0,1,2,4,5) with FIFO_DEPTH=4 while clk_en=0 -> the 5th write raises ovf for 1 clk; with clk_en enabled the first four are presented gaplessly, 96 ticks of continuous up_keyon in order 0,1,2,4.
- rst_n low at hold tick 10 -> up_keyon=0, busy=0 at that edge; after release, a new write behaves as in the first scenario.
- wr_n held low for 20 clk -> exactly one enqueue.
- Under JT12_KON_WR_MERGE_EN: queue ch2 op 0x1, then ch2 op 0xF while another entry is held -> one ch2 presentation with keyon_op=0xF.

Source files
------------

// File: rtl/jt12_kon_pkg.sv
// Shared types and constants for the key-on write path: register address, slot
// count, queued entry layout and FSM states.
package jt12_kon_pkg;

  localparam logic [7:0] KON_REG_ADDR = 8'h28;
  localparam int         SLOTS        = 24;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] ch;
  } kon_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } kon_st_e;

  // Channel codes 3 and 7 name no channel.
  function automatic logic kon_ch_ok(input logic [2:0] ch);
    return ch[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/jt12_kon_wr_if.sv
// CPU write port plus the key-on update stream produced from it.
interface jt12_kon_wr_if;

  logic       cpu_cs_n;
  logic       cpu_wr_n;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;

  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic       up_keyon;
  logic       busy;
  logic       ovf;

  modport master (
    output cpu_cs_n, cpu_wr_n, cpu_addr, cpu_din,
    input  keyon_op, keyon_ch, up_keyon, busy, ovf
  );

  modport slave (
    input  cpu_cs_n, cpu_wr_n, cpu_addr, cpu_din,
    output keyon_op, keyon_ch, up_keyon, busy, ovf
  );

endinterface

// File: rtl/jt12_kon_fifo.sv
// Synchronous FIFO of key-on entries with a per-entry channel-match port that
// rewrites the op mask of already queued entries in place.
module jt12_kon_fifo
  import jt12_kon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  kon_entry_t               din,
  output kon_entry_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     mrg_en,
  input  logic                     mrg_excl_head,
  input  logic [2:0]               mrg_ch,
  input  logic [3:0]               mrg_op,
  output logic                     mrg_hit
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  kon_entry_t       mem_q [DEPTH];
  kon_entry_t       mem_d [DEPTH];
  logic [DEPTH-1:0] hit_vec;

  // An entry is live when its distance from the read pointer is below count;
  // the head is excluded when it leaves this cycle, so a rewrite is never lost.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] off;
    logic          live;
    logic          is_head;
    assign off        = AW'(i) - rd_ptr_q;
    assign live       = {1'b0, off} < count_q;
    assign is_head    = AW'(i) == rd_ptr_q;
    assign hit_vec[i] = mrg_en & live & ~(mrg_excl_head & is_head)
                      & (mem_q[i].ch == mrg_ch);
  end

  assign mrg_hit = |hit_vec;
  assign dout    = mem_q[rd_ptr_q];
  assign full    = count_q == (AW+1)'(DEPTH);
  assign empty   = count_q == '0;
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++)
      if (hit_vec[i]) mem_d[i].op = mrg_op;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/jt12_kon_wr.sv
// Decodes CPU writes to register 0x28 (bank 0), queues them and presents each
// for one full slot revolution. Define JT12_KON_WR_MERGE_EN to fold repeated
// writes to a queued channel into that entry.
module jt12_kon_wr
  import jt12_kon_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD       = SLOTS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  jt12_kon_wr_if.slave bus
);

  localparam int CW = $clog2(HOLD);
  localparam int QW = $clog2(FIFO_DEPTH) + 1;

`ifdef JT12_KON_WR_MERGE_EN
  localparam bit MERGE_ON = 1'b1;
`else
  localparam bit MERGE_ON = 1'b0;
`endif

  logic          idle_prev_q, idle_prev_d;
  logic [7:0]    latch_q, latch_d;
  logic          bank_q, bank_d;
  kon_st_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [2:0]    ch_q, ch_d;
  logic          up_q, up_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;

  logic          strobe, kon_wr, pop, push, merge;
  logic          fifo_full, fifo_empty, mrg_hit;
  logic [QW-1:0] fifo_cnt, cnt_nxt;
  kon_entry_t    head, wr_ent;
  logic          unused_din3;

  assign unused_din3 = bus.cpu_din[3];
  assign wr_ent      = '{op: bus.cpu_din[7:4], ch: bus.cpu_din[2:0]};

  // Decode and slot-revolution FSM.
  always_comb begin
    idle_prev_d = bus.cpu_cs_n | bus.cpu_wr_n;
    strobe      = ~idle_prev_d & idle_prev_q;
    latch_d     = latch_q;
    bank_d      = bank_q;
    if (strobe & ~bus.cpu_addr[0]) begin
      latch_d = bus.cpu_din;
      bank_d  = bus.cpu_addr[1];
    end
    kon_wr = strobe & bus.cpu_addr[0] & (latch_q == KON_REG_ADDR) & ~bank_q
           & ~bus.cpu_addr[1] & kon_ch_ok(bus.cpu_din[2:0]);

    state_d = state_q;
    cnt_d   = cnt_q;
    up_d    = up_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE:
        if (clk_en & ~fifo_empty) begin
          pop     = 1'b1;
          up_d    = 1'b1;
          cnt_d   = CW'(HOLD - 1);
          state_d = ST_HOLD;
        end
      ST_HOLD:
        if (clk_en) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (~fifo_empty) begin
            pop   = 1'b1;
            cnt_d = CW'(HOLD - 1);
          end else begin
            up_d    = 1'b0;
            state_d = ST_IDLE;
          end
        end
      default: state_d = ST_IDLE;
    endcase

    op_d = op_q;
    ch_d = ch_q;
    if (pop) begin
      op_d = head.op;
      ch_d = head.ch;
    end
  end

  // Enqueue / overflow; a pop in the same clk frees the slot for the write.
  always_comb begin
    merge   = mrg_hit;
    push    = kon_wr & ~merge & (~fifo_full | pop);
    ovf_d   = kon_wr & ~merge & fifo_full & ~pop;
    cnt_nxt = fifo_cnt + QW'(push) - QW'(pop);
    busy_d  = (cnt_nxt != '0) | up_d;
  end

  jt12_kon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (push),
    .pop           (pop),
    .din           (wr_ent),
    .dout          (head),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .count         (fifo_cnt),
    .mrg_en        (kon_wr & MERGE_ON),
    .mrg_excl_head (pop),
    .mrg_ch        (wr_ent.ch),
    .mrg_op        (wr_ent.op),
    .mrg_hit       (mrg_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_prev_q <= 1'b1;
      latch_q     <= 8'h00;
      bank_q      <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      ch_q        <= '0;
      up_q        <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      idle_prev_q <= idle_prev_d;
      latch_q     <= latch_d;
      bank_q      <= bank_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ch_q        <= ch_d;
      up_q        <= up_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.keyon_op = op_q;
  assign bus.keyon_ch = ch_q;
  assign bus.up_keyon = up_q;
  assign bus.busy     = busy_q;
  assign bus.ovf      = ovf_q;

endmodule
